// File: rtl/amt_repair_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// amt_repair_ctrl_pkg
// Shared definitions for the AMT -> RMT repair sequencer.
//   - repair_state_e : IDLE / READ / DRAIN sequencer states
//   - repair_pkt_t   : one repair packet (per-lane valid, RMT index, phys tag),
//                      sized from `SIZE_RMT_LOG / `SIZE_PHYSICAL_LOG so the RMT
//                      side can reuse the same type
//   - lane_in_range  : helper deciding whether a lane address hits a real entry
// ---------------------------------------------------------------------------
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 6
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

package amt_repair_ctrl_pkg;

    localparam int AMT_DEPTH = 34;
    localparam int RMT_LOG   = `SIZE_RMT_LOG;
    localparam int PHYS_LOG  = `SIZE_PHYSICAL_LOG;
    localparam int PKT_LANES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } repair_state_e;

    typedef struct packed {
        logic [PKT_LANES-1:0]               laneValid;
        logic [PKT_LANES-1:0][RMT_LOG-1:0]  addr;
        logic [PKT_LANES-1:0][PHYS_LOG-1:0] data;
    } repair_pkt_t;

    function automatic logic lane_in_range(input int unsigned addr,
                                           input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/amt_repair_ctrl_if.sv
// ---------------------------------------------------------------------------
// amt_repair_ctrl_if
// Repair-packet channel from the repair sequencer to the rename map table.
//   pktValid_o     : packet valid           (sequencer -> RMT)
//   pktReady_i     : RMT accepts packet     (RMT -> sequencer)
//   pktAddr_o      : RMT index per lane     (sequencer -> RMT)
//   pktData_o      : physical tag per lane  (sequencer -> RMT)
//   pktLaneValid_o : per-lane write enable  (sequencer -> RMT)
// Modports: master = sequencer side, slave = RMT side.
// ---------------------------------------------------------------------------
interface amt_repair_ctrl_if
    import amt_repair_ctrl_pkg::*;
#(
    parameter int N_PACKETS = PKT_LANES,
    parameter int INDEX     = RMT_LOG,
    parameter int WIDTH     = PHYS_LOG
) ();

    logic                               pktValid_o;
    logic                               pktReady_i;
    logic [N_PACKETS-1:0][INDEX-1:0]    pktAddr_o;
    logic [N_PACKETS-1:0][WIDTH-1:0]    pktData_o;
    logic [N_PACKETS-1:0]               pktLaneValid_o;

    modport master (
        output pktValid_o,
        output pktAddr_o,
        output pktData_o,
        output pktLaneValid_o,
        input  pktReady_i
    );

    modport slave (
        input  pktValid_o,
        input  pktAddr_o,
        input  pktData_o,
        input  pktLaneValid_o,
        output pktReady_i
    );

endinterface

// File: rtl/amt_repair_ctrl.sv
// ---------------------------------------------------------------------------
// amt_repair_ctrl
// Walks the architectural map table N_PACKETS entries per cycle after a
// recovery request and streams registered repair packets to the RMT under
// valid/ready backpressure. Holds commit-side AMT writes off (repairBusy_o)
// while a repair is in flight.
//
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   startRepair_i    : one-cycle recovery request (ignored while busy)
//   amtRdAddr_o      : AMT repair read addresses, one per lane
//   amtRdData_i      : AMT repair read data (combinational read)
//   repairFlag_o     : AMT repairFlag_i, high while reading
//   repairBusy_o     : sequencer not idle; commit must not write the AMT
//   repairDone_o     : one-cycle pulse after the final packet is accepted
//   pkt              : repair-packet channel (amt_repair_ctrl_if.master)
//   repairCycles_o   : start-to-done cycles of last repair, saturating
//                      (only with AMT_REPAIR_PERF_EN)
//   repairCount_o    : completed repairs, wrapping (only with AMT_REPAIR_PERF_EN)
//
// Build option: define AMT_REPAIR_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module amt_repair_ctrl
    import amt_repair_ctrl_pkg::*;
#(
    parameter int DEPTH     = AMT_DEPTH,
    parameter int INDEX     = RMT_LOG,
    parameter int WIDTH     = PHYS_LOG,
    parameter int N_PACKETS = PKT_LANES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            startRepair_i,
    output logic [N_PACKETS-1:0][INDEX-1:0] amtRdAddr_o,
    input  logic [N_PACKETS-1:0][WIDTH-1:0] amtRdData_i,
    output logic                            repairFlag_o,
    output logic                            repairBusy_o,
    output logic                            repairDone_o,
`ifdef AMT_REPAIR_PERF_EN
    output logic [15:0]                     repairCycles_o,
    output logic [15:0]                     repairCount_o,
`endif
    amt_repair_ctrl_if.master               pkt
);

    // base is one bit wider than the index so it never wraps; lane sums get
    // one more bit so the range compare stays exact past the last packet.
    localparam int BW = INDEX + 1;
    localparam int SW = INDEX + 2;

    repair_state_e                   r_state;
    repair_state_e                   w_nextState;
    logic [BW-1:0]                   r_base;

    logic [N_PACKETS-1:0][INDEX-1:0] w_laneAddr;
    logic [N_PACKETS-1:0][WIDTH-1:0] w_laneData;
    logic [N_PACKETS-1:0]            w_laneValid;
    logic                            w_capture;
    logic                            w_lastPkt;
    logic                            w_accept;

    logic                            r_pktValid;
    logic [N_PACKETS-1:0][INDEX-1:0] r_pktAddr;
    logic [N_PACKETS-1:0][WIDTH-1:0] r_pktData;
    logic [N_PACKETS-1:0]            r_pktLaneValid;
    logic                            r_done;

    // Lanes past the end of the table are invalid and carry zero address/data.
    for (genvar g = 0; g < N_PACKETS; g++) begin : g_lane
        logic [SW-1:0] w_sum;
        assign w_sum          = SW'(r_base) + SW'(g);
        assign w_laneValid[g] = lane_in_range(32'(w_sum), DEPTH);
        assign w_laneAddr[g]  = w_laneValid[g] ? w_sum[INDEX-1:0] : '0;
        assign w_laneData[g]  = w_laneValid[g] ? amtRdData_i[g] : '0;
    end

    assign w_lastPkt = (SW'(r_base) + SW'(N_PACKETS)) >= SW'(DEPTH);
    assign w_accept  = r_pktValid && pkt.pktReady_i;
    // The output register can take a new packet when empty or being drained.
    assign w_capture = (r_state == READ) && (!r_pktValid || pkt.pktReady_i);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (startRepair_i)          w_nextState = READ;
            READ:    if (w_capture && w_lastPkt) w_nextState = DRAIN;
            DRAIN:   if (w_accept)               w_nextState = IDLE;
            default:                             w_nextState = IDLE;
        endcase
    end

    // ---- state-decoded outputs ----
    always_comb begin
        repairFlag_o = (r_state == READ);
        repairBusy_o = (r_state != IDLE);
        amtRdAddr_o  = (r_state == READ) ? w_laneAddr : '0;
    end

    // ---- packet stage: base pointer and registered repair packet ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_base         <= '0;
            r_pktValid     <= 1'b0;
            r_pktAddr      <= '0;
            r_pktData      <= '0;
            r_pktLaneValid <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && startRepair_i) begin
                r_base <= '0;
            end
            if (w_capture) begin
                r_base         <= r_base + BW'(N_PACKETS);
                r_pktValid     <= 1'b1;
                r_pktAddr      <= w_laneAddr;
                r_pktData      <= w_laneData;
                r_pktLaneValid <= w_laneValid;
            end else if (r_state == DRAIN && w_accept) begin
                r_pktValid <= 1'b0;
                r_done     <= 1'b1;
            end
        end
    end

    assign pkt.pktValid_o     = r_pktValid;
    assign pkt.pktAddr_o      = r_pktAddr;
    assign pkt.pktData_o      = r_pktData;
    assign pkt.pktLaneValid_o = r_pktLaneValid;
    assign repairDone_o       = r_done;

`ifdef AMT_REPAIR_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_cycCnt;
    logic [15:0] r_repairCycles;
    logic [15:0] r_repairCount;

    // r_cycCnt equals the cycle number since the start edge, so the value
    // latched with the done pulse is the cycle in which done is visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycCnt       <= '0;
            r_repairCycles <= '0;
            r_repairCount  <= '0;
        end else begin
            if (r_state == IDLE && startRepair_i) begin
                r_cycCnt <= 16'd1;
            end else if (r_state != IDLE) begin
                r_cycCnt <= sat_inc16(r_cycCnt);
            end
            if (r_state == DRAIN && w_accept) begin
                r_repairCycles <= sat_inc16(r_cycCnt);
                r_repairCount  <= r_repairCount + 16'd1;
            end
        end
    end

    assign repairCycles_o = r_repairCycles;
    assign repairCount_o  = r_repairCount;
`endif

endmodule

// File: tb/tb_amt_repair_ctrl.sv
// ---------------------------------------------------------------------------
// tb_amt_repair_ctrl
// Directed bench for amt_repair_ctrl. Two instances: DEPTH=34 and DEPTH=32,
// both with N_PACKETS=8. The AMT is modelled as entry i holding tag i.
// Define AMT_REPAIR_PERF_EN to also exercise the performance counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_amt_repair_ctrl;

    localparam int N   = 8;
    localparam int IDX = 6;
    localparam int W   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic sel32;
    logic rdy;
    logic start34, start32;

    assign start34 = start & ~sel32;
    assign start32 = start & sel32;

    logic [N-1:0][IDX-1:0] rdAddr34, rdAddr32;
    logic [N-1:0][W-1:0]   rdData34, rdData32;
    logic flag34, busy34, done34;
    logic flag32, busy32, done32;
`ifdef AMT_REPAIR_PERF_EN
    logic [15:0] cycles34, count34, cycles32, count32;
`endif

    amt_repair_ctrl_if #(.N_PACKETS(N), .INDEX(IDX), .WIDTH(W)) if34 ();
    amt_repair_ctrl_if #(.N_PACKETS(N), .INDEX(IDX), .WIDTH(W)) if32 ();

    assign if34.pktReady_i = rdy;
    assign if32.pktReady_i = rdy;

    // AMT model: entry i holds physical tag i
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rdData34[i] = W'(rdAddr34[i]);
            rdData32[i] = W'(rdAddr32[i]);
        end
    end

    amt_repair_ctrl #(.DEPTH(34), .INDEX(IDX), .WIDTH(W), .N_PACKETS(N)) dut34 (
        .clk           (clk),
        .reset         (reset),
        .startRepair_i (start34),
        .amtRdAddr_o   (rdAddr34),
        .amtRdData_i   (rdData34),
        .repairFlag_o  (flag34),
        .repairBusy_o  (busy34),
        .repairDone_o  (done34),
`ifdef AMT_REPAIR_PERF_EN
        .repairCycles_o(cycles34),
        .repairCount_o (count34),
`endif
        .pkt           (if34)
    );

    amt_repair_ctrl #(.DEPTH(32), .INDEX(IDX), .WIDTH(W), .N_PACKETS(N)) dut32 (
        .clk           (clk),
        .reset         (reset),
        .startRepair_i (start32),
        .amtRdAddr_o   (rdAddr32),
        .amtRdData_i   (rdData32),
        .repairFlag_o  (flag32),
        .repairBusy_o  (busy32),
        .repairDone_o  (done32),
`ifdef AMT_REPAIR_PERF_EN
        .repairCycles_o(cycles32),
        .repairCount_o (count32),
`endif
        .pkt           (if32)
    );

    // view of whichever instance is under test
    logic                  m_valid, m_flag, m_busy, m_done;
    logic [N-1:0][IDX-1:0] m_addr, m_rdAddr;
    logic [N-1:0][W-1:0]   m_data;
    logic [N-1:0]          m_lv;

    always_comb begin
        if (sel32) begin
            m_valid = if32.pktValid_o; m_addr = if32.pktAddr_o;
            m_data  = if32.pktData_o;  m_lv   = if32.pktLaneValid_o;
            m_flag  = flag32; m_busy = busy32; m_done = done32; m_rdAddr = rdAddr32;
        end else begin
            m_valid = if34.pktValid_o; m_addr = if34.pktAddr_o;
            m_data  = if34.pktData_o;  m_lv   = if34.pktLaneValid_o;
            m_flag  = flag34; m_busy = busy34; m_done = done34; m_rdAddr = rdAddr34;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected packet for a given base: lanes below depth carry index/tag = base+i
    function automatic void build(input int base, input int depth,
                                  output logic [63:0] a, output logic [63:0] d,
                                  output logic [63:0] lv);
        a = '0; d = '0; lv = '0;
        for (int i = 0; i < N; i++) begin
            if (base + i < depth) begin
                a[i*IDX +: IDX] = IDX'(base + i);
                d[i*W +: W]     = W'(base + i);
                lv[i]           = 1'b1;
            end
        end
    endfunction

    task automatic check_idle(input string nm);
        chk({nm, ":valid"},  m_valid,  0);
        chk({nm, ":busy"},   m_busy,   0);
        chk({nm, ":flag"},   m_flag,   0);
        chk({nm, ":done"},   m_done,   0);
        chk({nm, ":rdaddr"}, m_rdAddr, 0);
        chk({nm, ":addr"},   m_addr,   0);
        chk({nm, ":data"},   m_data,   0);
        chk({nm, ":lv"},     m_lv,     0);
    endtask

    // One repair: start pulse, optional stall of stall_len cycles on packet
    // stall_pkt, optional extra start pulse in cycle restart_cyc.
    task automatic run_repair(input string nm, input int depth, input int stall_pkt,
                              input int stall_len, input int restart_cyc,
                              input int exp_done, input int exp_pkts);
        int n_pkts = 0;
        int n_done = 0;
        int stall_left = stall_len;
        int captured;
        logic [63:0] ea, ed, elv;
        start = 1'b1; rdy = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
            start = (cyc == restart_cyc);
            rdy   = 1'b1;
            if (m_valid && n_pkts == stall_pkt && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            chk({nm, ":busy"}, m_busy, (cyc < exp_done));
            chk({nm, ":flag"}, m_flag, (cyc <= exp_done - 2));
            chk({nm, ":done"}, m_done, (cyc == exp_done));
            captured = n_pkts + (m_valid ? 1 : 0);
            build(captured * N, depth, ea, ed, elv);
            chk({nm, ":rdaddr"}, m_rdAddr, (cyc <= exp_done - 2) ? ea : 64'd0);
            if (m_valid) begin
                build(n_pkts * N, depth, ea, ed, elv);
                chk({nm, ":pktaddr"}, m_addr, ea);
                chk({nm, ":pktdata"}, m_data, ed);
                chk({nm, ":pktlv"},   m_lv,   elv);
                if (rdy) n_pkts++;
            end
            if (m_done) n_done++;
            step();
        end
        start = 1'b0;
        chk({nm, ":npkts"}, n_pkts, exp_pkts);
        chk({nm, ":ndone"}, n_done, 1);
    endtask

    initial begin
        logic [63:0] ea, ed, elv;
        reset = 1'b0; start = 1'b0; sel32 = 1'b0; rdy = 1'b0;
        step();
        step();
        check_idle("reset34");
        sel32 = 1'b1;
        #1;
        check_idle("reset32");
        sel32 = 1'b0;
        reset = 1'b1;
        step();

        // full repair, ready always high: 5 packets, done in cycle 7
        run_repair("basic", 34, -1, 0, -1, 7, 5);
        // ready low 3 cycles on packet 2: done moves to cycle 10
        run_repair("stall", 34, 2, 3, -1, 10, 5);
        // extra start while busy is ignored
        run_repair("restart", 34, -1, 0, 3, 7, 5);

        // reset while packet 3 is on the channel
        start = 1'b1; rdy = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        build(24, 34, ea, ed, elv);
        chk("midrst:pkt3addr", m_addr, ea);
        chk("midrst:pkt3valid", m_valid, 1);
        reset = 1'b0;
        step();
        check_idle("midrst");
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("midrst:nodone", m_done, 0);
            chk("midrst:notbusy", m_busy, 0);
        end
        // a fresh start after the abort repairs from base 0
        run_repair("after_rst", 34, -1, 0, -1, 7, 5);

        // DEPTH=32: 4 full packets, done in cycle 6
        sel32 = 1'b1;
        #1;
        run_repair("d32", 32, -1, 0, -1, 6, 4);
        sel32 = 1'b0;
        #1;

`ifdef AMT_REPAIR_PERF_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        rdy   = 1'b1;
        chk("perf:cyc_rst", cycles34, 0);
        chk("perf:cnt_rst", count34, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("perf:done1", done34, 1);
        chk("perf:cyc1", cycles34, 7);
        chk("perf:cnt1", count34, 1);
        // back-to-back start in the done cycle is accepted
        start = 1'b1;
        step();
        start = 1'b0;
        chk("perf:busy2", busy34, 1);
        repeat (6) step();
        chk("perf:done2", done34, 1);
        chk("perf:cyc2", cycles34, 7);
        chk("perf:cnt2", count34, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/amt_repair_ctrl.md
Name: amt_repair_ctrl

Overview:
Sequences architectural-map-table (AMT) reads during pipeline recovery. On a recovery request it walks the whole AMT N_PACKETS entries per cycle and streams registered repair packets to the rename map table (RMT) with valid/ready backpressure. It drives the AMT repair read ports and the AMT repairFlag_i, and holds commit-side AMT writes off while a repair is in flight. Sits between the recovery logic, the AMT and the RMT.

Parameters:
DEPTH, 34, AMT entries (logical registers).
INDEX, 6, AMT index width; must satisfy 2^INDEX >= DEPTH.
WIDTH, 7, AMT entry width (physical register tag).
N_PACKETS, 8, entries read and repaired per cycle.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
startRepair_i  in  1  one-cycle recovery request
amtRdAddr_o  out  N_PACKETS x INDEX  to AMT repairAddr_i
amtRdData_i  in  N_PACKETS x WIDTH  from AMT repairData_o (combinational read)
repairFlag_o  out  1  to AMT repairFlag_i; high while reading
repairBusy_o  out  1  state != IDLE; commit must not write the AMT
pktValid_o  out  1  repair packet valid
pktReady_i  in  1  RMT accepts packet
pktAddr_o  out  N_PACKETS x INDEX  RMT index per lane
pktData_o  out  N_PACKETS x WIDTH  physical tag per lane
pktLaneValid_o  out  N_PACKETS  per-lane write enable
repairDone_o  out  1  one-cycle pulse after the final packet is accepted

Behaviour:
- One clock (clk); reset synchronous, active-low: when reset==0 at a posedge -> state IDLE, base=0, and all outputs 0 (amtRdAddr_o, pkt* fields and repairDone_o included).
- States: IDLE, READ, DRAIN.
- IDLE: startRepair_i=1 -> READ with base=0. repairFlag_o=0, repairBusy_o=0.
- READ: repairFlag_o=1, repairBusy_o=1.
  - Lane i drives amtRdAddr_o[i]=base+i when base+i<DEPTH, else 0.
  - Capture condition: pktValid_o==0 or pktReady_i==1.
  - On capture: pktAddr_o[i]=base+i, pktData_o[i]=amtRdData_i[i], pktLaneValid_o[i]=(base+i<DEPTH), pktValid_o=1, base+=N_PACKETS.
  - If base+N_PACKETS>=DEPTH at capture -> DRAIN.
  - No capture: packet fields and base hold.
- DRAIN: repairFlag_o=0, repairBusy_o=1. When pktValid_o && pktReady_i: pktValid_o<=0, repairDone_o<=1 for one cycle, state -> IDLE.
- READ with pktReady_i=1 and no capture (pktValid_o==1 only): pktValid_o stays 1; capture is always taken when allowed.
- Packet fields are stable while pktValid_o=1 and pktReady_i=0.
- base is INDEX+1 bits wide, so it never wraps. Lanes with address >= DEPTH are invalid and present 0 address and 0 data.
- Packet count is ceil(DEPTH/N_PACKETS). With pktReady_i held 1, repairDone_o is high in cycle ceil(DEPTH/N_PACKETS)+2 after the start edge.
- startRepair_i while busy: ignored; the repair in flight completes unchanged.
- startRepair_i in the same cycle repairDone_o is high: accepted (state is IDLE).
- reset==0 mid-repair: immediate IDLE. No done pulse. The partially repaired RMT is the recovery logic's responsibility.

Optional Feature:
AMT_REPAIR_PERF_EN.
- Defined: adds output repairCycles_o[15:0], the cycles from start to done for the last repair (saturating), and output repairCount_o[15:0], completed repairs (wrapping). Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package: state enum (IDLE/READ/DRAIN) and a repair-packet struct typedef {laneValid, addr[], data[]} parameterised via `SIZE_RMT_LOG/`SIZE_PHYSICAL_LOG for RMT reuse.
- Single module; no sub-module is warranted. The perf counters stay inline under the macro.

Test Plan:
- DEPTH=34, N_PACKETS=8, AMT reset (entry i=i), pktReady_i=1, start pulse -> 5 packets with base 0,8,16,24,32; the last has pktLaneValid_o=8'b00000011 and data 32,33; repairDone_o in cycle 7; repairFlag_o high cycles 1-5.
- Same setup, pktReady_i low for 3 cycles on packet 2 -> packet 2 fields stable for 4 cycles, no address skipped, repairDone_o delayed by 3.
- startRepair_i reasserted during READ -> ignored; exactly 5 packets and one done pulse.
- reset=0 during packet 3 -> next cycle pktValid_o=0, repairBusy_o=0, no repairDone_o; a new start repairs from base 0.
- DEPTH=32, N_PACKETS=8 -> 4 packets, all lanes valid, done in cycle 6.
- AMT_REPAIR_PERF_EN defined, two back-to-back repairs with ready=1 -> repairCycles_o=7, repairCount_o=2.
